// File: rtl/reg_cmd_sequencer.sv
// Command sequencer driving a 16-bit clear/load/inc/dec register one byte or step
// per cycle, with a shadow copy of the downstream register contents.
module reg_cmd_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [7:0]  I,
  output logic [1:0]  FunSel,
  output logic        LH,
  output logic        enable,
  output logic [15:0] shadow,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_HI, S_STEP} state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;

  state_t           r_state, w_nstate;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_hi, w_hi;
  logic [7:0]       w_i;
  logic [1:0]       w_fs;
  logic             w_lh, w_en, w_done;
  logic             w_accept;
  logic [CNT_W-1:0] w_n;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = ~cmd_ready;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_n       = cmd_data[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_LOAD) w_nstate = S_LOAD_HI;
          else if (cmd_op[1] && (w_n > CNT_W'(1))) w_nstate = S_STEP;
        end
      end
      S_LOAD_HI: w_nstate = S_IDLE;
      S_STEP:    if (r_cnt == CNT_W'(1)) w_nstate = S_IDLE;
      default:   w_nstate = S_IDLE;
    endcase
  end

  // Next values of the registered drive outputs; the last step cycle sits in IDLE
  // so a new command can be accepted on the edge that ends it.
  always_comb begin
    w_en   = 1'b0;
    w_fs   = 2'b00;
    w_lh   = 1'b0;
    w_i    = 8'h00;
    w_done = 1'b0;
    w_cnt  = r_cnt;
    w_hi   = r_hi;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_CLEAR: begin
              w_en   = 1'b1;
              w_done = 1'b1;
            end
            OP_LOAD: begin
              w_en = 1'b1;
              w_fs = OP_LOAD;
              w_i  = cmd_data[7:0];
              w_hi = cmd_data[15:8];
            end
            default: begin
              if (w_n == '0) begin
                w_done = 1'b1;
              end else begin
                w_en   = 1'b1;
                w_fs   = cmd_op;
                w_cnt  = w_n - CNT_W'(1);
                w_done = (w_n == CNT_W'(1));
              end
            end
          endcase
        end
      end
      S_LOAD_HI: begin
        w_en   = 1'b1;
        w_fs   = OP_LOAD;
        w_lh   = 1'b1;
        w_i    = r_hi;
        w_done = 1'b1;
      end
      S_STEP: begin
        w_en   = 1'b1;
        w_fs   = FunSel;
        w_cnt  = r_cnt - CNT_W'(1);
        w_done = (r_cnt == CNT_W'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= 1'b0;
      FunSel <= 2'b00;
      LH     <= 1'b0;
      I      <= 8'h00;
      done   <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= 8'h00;
    end else begin
      enable <= w_en;
      FunSel <= w_fs;
      LH     <= w_lh;
      I      <= w_i;
      done   <= w_done;
      r_cnt  <= w_cnt;
      r_hi   <= w_hi;
    end
  end

  // Shadow follows what the downstream register does with the current drive values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 16'h0000;
    end else if (enable) begin
      case (FunSel)
        2'b00:   shadow <= 16'h0000;
        2'b01:   if (LH) shadow[15:8] <= I;
                 else    shadow[7:0]  <= I;
        2'b10:   shadow <= shadow - 16'd1;
        default: shadow <= shadow + 16'd1;
      endcase
    end
  end

endmodule

// File: doc/reg_cmd_sequencer.md
REG_CMD_SEQUENCER -- requirements
Module: reg_cmd_sequencer

Interface
REQ-001 Parameter: CNT_W, default 8, width of INC/DEC step count taken from cmd_data[CNT_W-1:0].
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_op  input  2  00 CLEAR, 01 LOAD16, 10 DEC_N, 11 INC_N.
REQ-007 cmd_data  input  16  LOAD16 word; for INC_N/DEC_N, step count N in bits [CNT_W-1:0]; ignored for CLEAR.
REQ-008 I  output  8  byte to downstream 16-bit register.
REQ-009 FunSel  output  2  downstream function: 00 clear, 01 byte load, 10 decrement, 11 increment.
REQ-010 LH  output  1  byte-load half select: 0 = bits [7:0], 1 = bits [15:8].
REQ-011 enable  output  1  downstream register update enable.
REQ-012 shadow  output  16  model of the downstream register contents.
REQ-013 done  output  1  one-cycle pulse marking command completion.
REQ-014 busy  output  1  equals NOT cmd_ready.

Function
REQ-015 The block SHALL be a registered-output FSM with states IDLE, LOAD_HI and STEP; cmd_ready SHALL be 1 exactly when state is IDLE.
REQ-016 A command is accepted on a posedge with cmd_valid=1, cmd_ready=1 and rst=0; cmd_op and cmd_data are captured at that edge only.
REQ-017 Idle drive values (no command driving): enable=0, FunSel=00, LH=0, I=0x00.
REQ-018 CLEAR: for the one cycle after acceptance, drive enable=1, FunSel=00; done=1 in that cycle; state stays IDLE, so back-to-back CLEARs are accepted every cycle.
REQ-019 LOAD16: cycle after acceptance, drive enable=1, FunSel=01, LH=0, I=cmd_data[7:0]; state LOAD_HI. The following cycle, drive LH=1, I=cmd_data[15:8], done=1; state returns to IDLE. Throughput: one LOAD16 per 2 cycles.
REQ-020 INC_N/DEC_N with N>=1: drive enable=1, FunSel=11 (INC) or 10 (DEC) for exactly N consecutive cycles starting the cycle after acceptance; state STEP with a down-counter loaded with N-1; done=1 in the last drive cycle; state is IDLE in that last drive cycle, allowing the next command to be accepted on the edge that ends it.
REQ-021 INC_N/DEC_N with N=0: no drive (enable stays 0), done=1 in the cycle after acceptance; state stays IDLE.
REQ-022 shadow SHALL update on every posedge where enable=1: FunSel 00 -> 0x0000; 01 -> the byte selected by LH replaced with I, the other byte preserved; 10 -> shadow-1; 11 -> shadow+1; arithmetic modulo 2^16 (0x0000-1 = 0xFFFF, 0xFFFF+1 = 0x0000).
REQ-023 shadow SHALL hold its value on any posedge where enable=0.
REQ-024 The downstream register has no reset, so system software SHALL issue CLEAR after reset before shadow is valid; the block itself does not auto-clear downstream.
REQ-025 cmd_valid while cmd_ready=0 SHALL have no effect; the upstream producer holds the command until accepted.
REQ-026 An undefined or X-free cmd_op is always one of the four encodings; no illegal-op state exists.

Reset
REQ-027 On a posedge with rst=1: state IDLE, counter 0, enable=0, FunSel=00, LH=0, I=0x00, done=0, shadow=0x0000; cmd_ready=1 the next cycle.
REQ-028 rst SHALL take priority over command acceptance and SHALL abort any LOAD16 or STEP in progress without a done pulse; the downstream update from the cycle in which rst is asserted still occurs on that edge, but shadow is forced to 0x0000.

Verification
REQ-029 rst, then CLEAR -> one cycle enable=1, FunSel=00, done=1; shadow=0x0000.
REQ-030 LOAD16 0xA55A -> cycle1 FunSel=01, LH=0, I=0x5A; cycle2 LH=1, I=0xA5, done=1; cmd_ready low in cycle1 only; shadow=0xA55A.
REQ-031 From shadow 0xFFFE, INC_N N=3 -> 3 cycles enable=1, FunSel=11; done in cycle3; shadow=0x0001 (wrap).
REQ-032 DEC_N N=0 -> enable never asserted, done=1 the next cycle, shadow unchanged.
REQ-033 INC_N N=10 from 0x0000, rst asserted after 4 drive cycles -> the next cycle enable=0, cmd_ready=1, no done pulse, shadow=0x0000.
REQ-034 cmd_valid held high with CLEAR, LOAD16 0x1234, DEC_N N=2 queued in order -> accepts at cycles 0, 1 and 3; shadow sequence 0x0000, 0x0034, 0x1234, 0x1233, 0x1232.
